fpu_result_collector: RTL

- Consumer end of the FPU result interface: samples `data_out`/`status_out`/`flags_out` from `fpu` and buffers each completed result in a show-ahead FIFO.
- Keeps per-status-class statistics for the FPU test harness.
- Sits between `fpu` and the harness readout logic, on the same 100 kHz clock domain.

---
 rtl/fpu_result_collector.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fpu_result_collector.sv
// fpu_result_collector
// Consumer end of the FPU result interface. Each rising edge of the fpu
// result-ready level (flag_in) captures {status_in, data_in} into a show-ahead
// FIFO and updates per-status-class statistics counters.
//
// Read handshake: rd_data is valid whenever empty=0; asserting rd_en while
// empty=0 pops the head on that rising edge, and rd_en while empty=1 is ignored.
module fpu_result_collector #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                          clock100KHz,
    input  logic                          reset,
    input  logic [31:0]                   data_in,
    input  logic [3:0]                    status_in,
    input  logic                          flag_in,
    input  logic                          rd_en,
    input  logic                          clear_stats,
    output logic [35:0]                   rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic [CNT_W-1:0]              cnt_exact,
    output logic [CNT_W-1:0]              cnt_ovf,
    output logic [CNT_W-1:0]              cnt_unf,
    output logic [CNT_W-1:0]              cnt_inexact,
    output logic [CNT_W-1:0]              cnt_err,
    output logic [CNT_W-1:0]              cnt_drop,
    output logic                          overflow_sticky
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic            flag_prev;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [35:0]     mem [FIFO_DEPTH];

    logic            capture;
    logic            pop;
    logic            store;
    logic            drop;
    logic            one_hot;

    // A capture is the rising edge of the result-ready level.
    assign capture = flag_in & ~flag_prev;

    // Occupancy flags come from the entry count so a full FIFO is never
    // confused with an empty one when the pointers coincide.
    assign empty   = (level == '0);
    assign full    = (level == LW'(FIFO_DEPTH));

    // A pop frees the head slot on the same edge, so a full FIFO can still
    // accept a capture when it is popped in the same cycle.
    assign pop     = rd_en & ~empty;
    assign store   = capture & (~full | pop);
    assign drop    = capture & full & ~pop;
    assign one_hot = $onehot(status_in);

    assign rd_data = empty ? 36'd0 : mem[rd_ptr];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Edge detector, FIFO pointers and entry count.
    always_ff @(posedge clock100KHz) begin
        if (reset) begin
            flag_prev <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
        end else begin
            flag_prev <= flag_in;
            if (store) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({store, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Entry storage; contents are not cleared, a capture pending under reset is lost.
    always_ff @(posedge clock100KHz) begin
        if (!reset && store) begin
            mem[wr_ptr] <= {status_in, data_in};
        end
    end

    // Saturating statistics; clear_stats wins over a same-cycle capture.
    always_ff @(posedge clock100KHz) begin
        if (reset || clear_stats) begin
            cnt_exact       <= '0;
            cnt_ovf         <= '0;
            cnt_unf         <= '0;
            cnt_inexact     <= '0;
            cnt_err         <= '0;
            cnt_drop        <= '0;
            overflow_sticky <= 1'b0;
        end else begin
            if (capture) begin
                if (one_hot) begin
                    if (status_in[0]) cnt_exact   <= sat_inc(cnt_exact);
                    if (status_in[1]) cnt_ovf     <= sat_inc(cnt_ovf);
                    if (status_in[2]) cnt_unf     <= sat_inc(cnt_unf);
                    if (status_in[3]) cnt_inexact <= sat_inc(cnt_inexact);
                end else begin
                    cnt_err <= sat_inc(cnt_err);
                end
            end
            if (drop) begin
                cnt_drop        <= sat_inc(cnt_drop);
                overflow_sticky <= 1'b1;
            end
        end
    end

endmodule
